config_word_packer: RTL and testbench

Byte-to-word packer that feeds the fabric configuration port of `eFPGA_top`. It accepts a bitstream as a valid/ready byte stream and packs every four bytes into one big-endian 32-bit word. Each word is presented on `SelfWriteData` with a programmable setup/strobe/hold sequence on `SelfWriteStrobe`. It replaces testbench-driven bitstream loading with synthesizable RTL that sits directly upstream of the fabric's self-write interface.

---
 rtl/config_word_packer_if.sv | 18 +
 rtl/config_word_packer.sv | 100 ++++++++++
 tb/tb_config_word_packer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_word_packer_if.sv
// Bitstream byte channel into the configuration word packer.
// Valid/ready handshake; byte_last marks the final stream byte.
interface config_word_packer_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;

  modport master (
    output byte_data, byte_valid, byte_last,
    input  byte_ready
  );

  modport slave (
    input  byte_data, byte_valid, byte_last,
    output byte_ready
  );
endinterface

// File: rtl/config_word_packer.sv
// Packs bitstream bytes into big-endian 32-bit fabric config words
// and drives them out with a setup/strobe/hold write sequence.
module config_word_packer #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 2
) (
  input  logic                 CLK,
  input  logic                 resetn,
  config_word_packer_if.slave  bs,
  output logic [31:0]          SelfWriteData,
  output logic                 SelfWriteStrobe,
  output logic                 busy,
  output logic [15:0]          word_count
);

  typedef enum logic [1:0] {
    COLLECT,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYCLES - 1);

  state_t      state;
  logic [1:0]  idx;
  logic [31:0] acc;
  logic [31:0] merged;
  logic [3:0]  cnt;
  logic        take;
  logic        done;

  assign bs.byte_ready = (state == COLLECT);
  assign take = bs.byte_valid && (state == COLLECT);
  assign done = take && ((idx == 2'd3) || bs.byte_last);
  assign busy = (state != COLLECT) || (idx != 2'd0);

  // acc is kept zero below the current index, so a flush pads for free
  always_comb begin
    merged = acc;
    unique case (idx)
      2'd0: merged[31:24] = bs.byte_data;
      2'd1: merged[23:16] = bs.byte_data;
      2'd2: merged[15:8]  = bs.byte_data;
      2'd3: merged[7:0]   = bs.byte_data;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state           <= COLLECT;
      idx             <= 2'd0;
      acc             <= '0;
      cnt             <= '0;
      SelfWriteData   <= '0;
      SelfWriteStrobe <= 1'b0;
      word_count      <= '0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (done) begin
            SelfWriteData <= merged;
            acc           <= '0;
            cnt           <= SETUP_LD;
            state         <= SETUP;
          end else if (take) begin
            acc <= merged;
            idx <= idx + 2'd1;
          end
        end
        SETUP: begin
          if (cnt == 4'd0) begin
            SelfWriteStrobe <= 1'b1;
            state           <= STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        STROBE: begin
          SelfWriteStrobe <= 1'b0;
          if (word_count != 16'hFFFF) begin
            word_count <= word_count + 16'd1;
          end
          cnt   <= HOLD_LD;
          state <= HOLD;
        end
        HOLD: begin
          if (cnt == 4'd0) begin
            idx   <= 2'd0;
            state <= COLLECT;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_word_packer.sv
// Bench for config_word_packer: two instances (default and 1/3 timing)
// checked against a queue-based packing model.
module tb_config_word_packer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  d;
  logic        v;
  logic        l;
  bit          sel;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  config_word_packer_if i1 ();
  config_word_packer_if i2 ();

  logic [31:0] sw1, sw2;
  logic        st1, st2, bz1, bz2;
  logic [15:0] wc1, wc2;

  assign i1.byte_data  = d;
  assign i1.byte_last  = l;
  assign i1.byte_valid = v & ~sel;
  assign i2.byte_data  = d;
  assign i2.byte_last  = l;
  assign i2.byte_valid = v & sel;

  config_word_packer u1 (
    .CLK(clk), .resetn(resetn), .bs(i1),
    .SelfWriteData(sw1), .SelfWriteStrobe(st1),
    .busy(bz1), .word_count(wc1)
  );

  config_word_packer #(.SETUP_CYCLES(1), .HOLD_CYCLES(3)) u2 (
    .CLK(clk), .resetn(resetn), .bs(i2),
    .SelfWriteData(sw2), .SelfWriteStrobe(st2),
    .busy(bz2), .word_count(wc2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] q1d[$], q2d[$];
  int          q1c[$], q2c[$];
  int          run1 = 0, run2 = 0, low1 = 0, low2 = 0, dbl = 0;
  logic        p1 = 1'b0, p2 = 1'b0;

  always @(negedge clk) begin
    if (st1) begin q1d.push_back(sw1); q1c.push_back(cyc); end
    if (st2) begin q2d.push_back(sw2); q2c.push_back(cyc); end
    if ((st1 && p1) || (st2 && p2)) dbl <= dbl + 1;
    p1 <= st1;
    p2 <= st2;
    if (!i1.byte_ready) run1 <= run1 + 1;
    else begin if (run1 != 0) low1 <= run1; run1 <= 0; end
    if (!i2.byte_ready) run2 <= run2 + 1;
    else begin if (run2 != 0) low2 <= run2; run2 <= 0; end
  end

  function automatic logic rdy();
    return sel ? i2.byte_ready : i1.byte_ready;
  endfunction
  function automatic int cur_s();
    return sel ? 1 : 2;
  endfunction
  function automatic int cur_h();
    return sel ? 3 : 2;
  endfunction
  function automatic logic [15:0] cur_wc();
    return sel ? wc2 : wc1;
  endfunction

  logic [7:0]  pend[$];
  logic [31:0] ew[$];
  int          ec[$];
  int          mc[2];
  int          last_acc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_model(input logic [7:0] b, input logic last);
    logic [31:0] w;
    w = '0;
    pend.push_back(b);
    if (pend.size() == 4 || last) begin
      foreach (pend[i]) w |= 32'(pend[i]) << (24 - 8 * i);
      ew.push_back(w);
      ec.push_back(last_acc + cur_s());
      pend.delete();
    end
  endtask

  task automatic send(input logic [7:0] b, input logic last, input bit keep);
    int n;
    n = 0;
    d = b;
    l = last;
    v = 1'b1;
    while (!rdy() && n < 100) begin @(posedge clk); #1; n++; end
    chk("ready_wait", 32'(rdy()), 32'd1);
    @(posedge clk); #1;
    last_acc = cyc;
    push_model(b, last);
    if (!keep) v = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!rdy() && n < 100) begin @(posedge clk); #1; n++; end
    chk("ready_return", 32'(rdy()), 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic check_word(input bit do_cnt);
    int n, gc, xc;
    logic [31:0] gd, xw;
    n = 0;
    while ((sel ? q2d.size() : q1d.size()) == 0 && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk("strobe_seen", 32'((sel ? q2d.size() : q1d.size()) != 0), 32'd1);
    if ((sel ? q2d.size() : q1d.size()) == 0 || ew.size() == 0) return;
    gd = sel ? q2d.pop_front() : q1d.pop_front();
    gc = sel ? q2c.pop_front() : q1c.pop_front();
    xw = ew.pop_front();
    xc = ec.pop_front();
    chk("word_data", gd, xw);
    chk("strobe_cycle", 32'(gc), 32'(xc));
    mc[int'(sel)] = (mc[int'(sel)] == 16'hFFFF) ? 16'hFFFF : mc[int'(sel)] + 1;
    wait_ready();
    if (do_cnt) chk("word_count", 32'(cur_wc()), 32'(mc[int'(sel)]));
  endtask

  task automatic check_low();
    chk("ready_low_len", 32'(sel ? low2 : low1), 32'(cur_s() + 1 + cur_h()));
  endtask

  task automatic pulse_reset(input string tag);
    resetn = 1'b0;
    #1;
    chk({tag, "_strobe"}, 32'(sel ? st2 : st1), 32'd0);
    chk({tag, "_count"}, 32'(cur_wc()), 32'd0);
    chk({tag, "_ready"}, 32'(rdy()), 32'd1);
    chk({tag, "_busy"}, 32'(sel ? bz2 : bz1), 32'd0);
    chk({tag, "_data"}, sel ? sw2 : sw1, 32'd0);
    #2;
    resetn = 1'b1;
    q1d.delete(); q1c.delete(); q2d.delete(); q2c.delete();
    ew.delete(); ec.delete(); pend.delete();
    mc[0] = 0; mc[1] = 0;
    v = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int len, gap;
    logic lst;
    bit   kp;
    resetn = 1'b0; d = '0; v = 1'b0; l = 1'b0; sel = 1'b0;
    mc[0] = 0; mc[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(i1.byte_ready), 32'd1);
    chk("rst_data", sw1, 32'd0);
    chk("rst_strobe", 32'(st1), 32'd0);
    chk("rst_busy", 32'(bz1), 32'd0);
    chk("rst_count", 32'(wc1), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // zero-length stream: idle, nothing strobes
    repeat (20) @(posedge clk);
    #1;
    chk("idle_no_strobe", 32'(q1d.size() + q2d.size()), 32'd0);

    // basic word, default timing
    send(8'h12, 1'b0, 1'b1);
    send(8'h34, 1'b0, 1'b1);
    send(8'h56, 1'b0, 1'b1);
    send(8'h78, 1'b0, 1'b0);
    check_word(1'b1);
    check_low();

    // eight bytes with valid held high
    for (int i = 0; i < 8; i++) send(8'(i), 1'b0, i != 7);
    chk("two_words_gap", 32'(ec[1] - ec[0]), 32'd9);
    check_word(1'b0);
    check_word(1'b1);

    // partial flush then index restart
    send(8'hA1, 1'b0, 1'b0);
    chk("partial_busy", 32'(bz1), 32'd1);
    send(8'hB2, 1'b1, 1'b0);
    check_word(1'b1);
    send(8'hCC, 1'b0, 1'b0);
    send(8'hDD, 1'b0, 1'b0);
    send(8'hEE, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    check_word(1'b1);

    // reset during STROBE
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_strobe", 32'(st1), 32'd1);
    pulse_reset("rst_strobe");
    send(8'h9A, 1'b0, 1'b0);
    send(8'hBC, 1'b0, 1'b0);
    send(8'hDE, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    check_word(1'b1);

    // reset during HOLD, and with a partial word held
    for (int i = 0; i < 4; i++) send(8'h40 + 8'(i), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_hold_ready", 32'(i1.byte_ready), 32'd0);
    pulse_reset("rst_hold");
    send(8'h77, 1'b0, 1'b0);
    pulse_reset("rst_partial");
    for (int i = 0; i < 4; i++) send(8'h50 + 8'(i), 1'b0, 1'b0);
    check_word(1'b1);

    // alternate timing instance
    sel = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h60 + 8'(i), 1'b0, i != 3);
    check_word(1'b1);
    check_low();
    for (int i = 0; i < 8; i++) send(8'h80 + 8'(i), 1'b0, i != 7);
    chk("alt_two_words_gap", 32'(ec[1] - ec[0]), 32'd9);
    check_word(1'b0);
    check_word(1'b1);

    // randomized streams on both instances
    for (int it = 0; it < 24; it++) begin
      sel = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      for (int k = 0; k < len; k++) begin
        if (k == len - 1) lst = (pend.size() != 3) ? 1'b1 : 1'($urandom_range(0, 1));
        else lst = ($urandom_range(0, 5) == 0);
        kp = (k != len - 1) && ($urandom_range(0, 1) == 1);
        send(8'($urandom), lst, kp);
        if (!kp) begin
          gap = $urandom_range(0, 2);
          repeat (gap) @(posedge clk);
          #1;
        end
      end
      while (ew.size() != 0) check_word(1'b0);
      chk("rand_count", 32'(cur_wc()), 32'(mc[int'(sel)]));
    end

    // saturation of word_count
    sel = 1'b0;
    force u1.word_count = 16'hFFFE;
    @(posedge clk); #1;
    release u1.word_count;
    mc[0] = 16'hFFFE;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0, 1'b0);
      check_word(1'b1);
    end

    chk("no_double_strobe", 32'(dbl), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
